wr_arbiter: RTL and testbench
=============================

WR_ARBITER -- requirements
Module: wr_arbiter

Interface
REQ-001 Parameter CNT_WIDTH, default 6: width of each per-channel pending-request count.
REQ-002 Parameter MAX_SKIP, default 4: number of consecutive losses after which a pending channel is forced to win.
REQ-003 Parameter TIMEOUT, default 4096: maximum number of ddr_clk cycles the arbiter waits for ddr_wrdy or ddr_wdone.
REQ-004 ddr_clk  in  1  single clock; all logic is on its rising edge.
REQ-005 ddr_rst  in  1  synchronous, active-high reset.
REQ-006 ddr_wreq_cnt1/2/3  in  CNT_WIDTH  pending-burst count per write channel; 0 means idle.
REQ-007 ddr_wrdy  in  1  DDR controller accepted the write request.
REQ-008 ddr_wdone  in  1  single-cycle pulse: the write burst has completed.
REQ-009 ddr_wreq  out  1  write request to the DDR controller for the granted channel.
REQ-010 wr_opera_en_1/2/3  out  1 each  one-hot grant; steers the address, length and data muxes.
REQ-011 grant_id  out  2  granted channel: 0 = none, 1..3 = channel.
REQ-012 wr_done  out  1  single-cycle pulse on burst completion.
REQ-013 wr_timeout  out  1  single-cycle pulse on watchdog abort.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The state machine SHALL have four states: IDLE, ARB, REQ, WAIT.
REQ-016 IDLE->ARB on the cycle after any ddr_wreq_cntN is nonzero; otherwise the FSM stays in IDLE.
REQ-017 ARB lasts exactly one cycle, registers the winner into wr_opera_en_N and grant_id, then moves to REQ.
REQ-018 Winner selection, in priority order:
  - (a) a nonzero channel whose skip counter has reached MAX_SKIP;
  - (b) otherwise, the strictly largest count;
  - (c) ties go round-robin, starting from the channel after the last granted (reset pointer = channel 1, so channel 1 wins an all-equal tie first).
REQ-019 If several channels satisfy (a), the lowest-numbered one wins.
REQ-020 Channels with count 0 SHALL never be granted.
REQ-021 If every count is 0 in ARB, the FSM SHALL return to IDLE with no grant.
REQ-022 Per-channel skip counters (width clog2(MAX_SKIP+1)):
  - increment, saturating, when the channel is nonzero in ARB and loses;
  - clear when the channel wins or its count is 0.
REQ-023 REQ state:
  - ddr_wreq = 1, held until the cycle ddr_wrdy = 1;
  - on that cycle: ddr_wreq = 0 next cycle, FSM -> WAIT.
REQ-024 WAIT state:
  - ddr_wreq = 0;
  - on ddr_wdone = 1: one-cycle wr_done pulse, all grants clear, FSM -> IDLE.
REQ-025 The grant SHALL remain stable from ARB exit until the cycle after ddr_wdone; latency from ddr_wdone to the grant dropping is 1 cycle.
REQ-026 ddr_wdone seen in IDLE, ARB or REQ SHALL be ignored.
REQ-027 If ddr_wrdy and ddr_wdone are both high in REQ, wrdy is taken and wdone ignored.
REQ-028 Watchdog:
  - a 16-bit counter clears on entry to REQ and on entry to WAIT, and increments in both states;
  - when it reaches TIMEOUT-1: one-cycle wr_timeout pulse, ddr_wreq = 0, grants clear, FSM -> IDLE;
  - the round-robin pointer does not advance.
REQ-029 The round-robin pointer SHALL update to the winner only on a wr_done completion.
REQ-030 wr_opera_en_1/2/3 SHALL be one-hot or all-zero at all times.
REQ-031 Minimum back-to-back turnaround, wdone to the next ddr_wreq: 3 cycles (IDLE, ARB, REQ).
REQ-032 A count change during REQ or WAIT SHALL NOT alter the current grant.

Reset
REQ-033 On ddr_rst = 1 at a clock edge:
  - FSM = IDLE;
  - ddr_wreq, wr_opera_en_1/2/3, wr_done, wr_timeout and busy = 0;
  - grant_id = 0;
  - skip counters and watchdog = 0;
  - round-robin pointer = channel 1.
REQ-034 Reset asserted mid-burst SHALL drop ddr_wreq and all grants on the next edge, with no wr_done or wr_timeout pulse.

Verification
REQ-035 cnt = (3,7,2); wrdy 2 cycles after ddr_wreq; wdone 10 cycles later -> grant_id = 2, ddr_wreq high 3 cycles, wr_done pulses once, grant drops 1 cycle after wdone.
REQ-036 cnt = (5,5,5), four completed bursts -> grant order 1,2,3,1.
REQ-037 cnt2 = 9 held constant, cnt1 = 1, MAX_SKIP = 4 -> channel 2 wins 4 times, then channel 1 wins the 5th arbitration.
REQ-038 ddr_wrdy never asserted, TIMEOUT = 16 -> wr_timeout pulses 16 cycles after entry to REQ, FSM returns to IDLE, round-robin pointer unchanged.
REQ-039 ddr_rst asserted during WAIT -> ddr_wreq, grants and busy = 0 next cycle; no wr_done pulse; a stray wdone afterwards is ignored.
REQ-040 All counts 0; wdone and wrdy toggled randomly for 100 cycles -> ddr_wreq = 0, grant_id = 0, busy = 0 throughout.

Source files
------------

// File: rtl/wr_arbiter.sv
// Three-channel DDR write arbiter: starvation override, largest-count wins, round-robin ties.
// Owns the DDR write request handshake with a watchdog on ddr_wrdy / ddr_wdone.
module wr_arbiter #(
    parameter int CNT_WIDTH = 6,
    parameter int MAX_SKIP  = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 ddr_clk,
    input  logic                 ddr_rst,
    input  logic [CNT_WIDTH-1:0] ddr_wreq_cnt1,
    input  logic [CNT_WIDTH-1:0] ddr_wreq_cnt2,
    input  logic [CNT_WIDTH-1:0] ddr_wreq_cnt3,
    input  logic                 ddr_wrdy,
    input  logic                 ddr_wdone,
    output logic                 ddr_wreq,
    output logic                 wr_opera_en_1,
    output logic                 wr_opera_en_2,
    output logic                 wr_opera_en_3,
    output logic [1:0]           grant_id,
    output logic                 wr_done,
    output logic                 wr_timeout,
    output logic                 busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARB  = 2'd1;
    localparam logic [1:0] REQ  = 2'd2;
    localparam logic [1:0] WAIT = 2'd3;

    localparam int              SKIP_W   = $clog2(MAX_SKIP + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);
    localparam logic [15:0]     WD_LIMIT = 16'(TIMEOUT - 1);

    logic [1:0]           state;
    logic [15:0]          wd_cnt;
    logic [1:0]           rr_start;
    logic [CNT_WIDTH-1:0] cnt  [3];
    logic [SKIP_W-1:0]    skip [3];

    logic                 any_req;
    logic                 starved_hit;
    logic                 tie_hit;
    logic [1:0]           starved_idx;
    logic [1:0]           tie_idx;
    logic [1:0]           probe;
    logic [1:0]           win_idx;
    logic [CNT_WIDTH-1:0] max_cnt;

    assign cnt[0] = ddr_wreq_cnt1;
    assign cnt[1] = ddr_wreq_cnt2;
    assign cnt[2] = ddr_wreq_cnt3;

    // Channel indices are 0-based internally; grant_id is 1-based (0 = no grant).
    always_comb begin
        any_req     = 1'b0;
        starved_hit = 1'b0;
        starved_idx = '0;
        max_cnt     = '0;
        tie_hit     = 1'b0;
        tie_idx     = '0;
        probe       = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (cnt[i] != '0) begin
                any_req = 1'b1;
                if (!starved_hit && skip[i] == SKIP_MAX) begin
                    starved_hit = 1'b1;
                    starved_idx = 2'(i);
                end
            end
            if (cnt[i] > max_cnt) max_cnt = cnt[i];
        end
        for (int unsigned k = 0; k < 3; k++) begin
            probe = 2'((32'(rr_start) + k) % 3);
            if (!tie_hit && max_cnt != '0 && cnt[probe] == max_cnt) begin
                tie_hit = 1'b1;
                tie_idx = probe;
            end
        end
        win_idx = starved_hit ? starved_idx : tie_idx;
    end

    // Skip counters clear on any edge where their channel is idle, not just in ARB.
    always_ff @(posedge ddr_clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (ddr_rst || cnt[i] == '0) begin
                skip[i] <= '0;
            end else if (state == ARB) begin
                if (win_idx == 2'(i))
                    skip[i] <= '0;
                else if (skip[i] != SKIP_MAX)
                    skip[i] <= skip[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state      <= IDLE;
            ddr_wreq   <= 1'b0;
            grant_id   <= '0;
            wr_done    <= 1'b0;
            wr_timeout <= 1'b0;
            wd_cnt     <= '0;
            rr_start   <= '0;
        end else begin
            wr_done    <= 1'b0;
            wr_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) state <= ARB;
                end
                ARB: begin
                    if (any_req) begin
                        grant_id <= win_idx + 2'd1;
                        ddr_wreq <= 1'b1;
                        wd_cnt   <= '0;
                        state    <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (ddr_wrdy) begin
                        ddr_wreq <= 1'b0;
                        wd_cnt   <= '0;
                        state    <= WAIT;
                    end else if (wd_cnt == WD_LIMIT) begin
                        ddr_wreq   <= 1'b0;
                        grant_id   <= '0;
                        wr_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: begin
                    if (ddr_wdone) begin
                        wr_done  <= 1'b1;
                        grant_id <= '0;
                        // Next tie search starts at the channel after the one just served.
                        rr_start <= (grant_id == 2'd3) ? 2'd0 : grant_id;
                        state    <= IDLE;
                    end else if (wd_cnt == WD_LIMIT) begin
                        grant_id   <= '0;
                        wr_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign wr_opera_en_1 = (grant_id == 2'd1);
    assign wr_opera_en_2 = (grant_id == 2'd2);
    assign wr_opera_en_3 = (grant_id == 2'd3);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_wr_arbiter.sv
// Self-checking bench for wr_arbiter: directed scenarios plus randomized bursts
// checked against a transaction-level arbitration model.
module tb_wr_arbiter;

    localparam int CW       = 6;
    localparam int MAX_SKIP = 4;
    localparam int TIMEOUT  = 16;

    logic          ddr_clk = 1'b0;
    logic          ddr_rst;
    logic [CW-1:0] c1, c2, c3;
    logic          ddr_wrdy, ddr_wdone;
    logic          ddr_wreq, en1, en2, en3, wr_done, wr_timeout, busy;
    logic [1:0]    grant_id;
    logic [2:0]    en_vec;

    int n_assert = 0;
    int n_fail   = 0;

    int m_cnt  [1:3];
    int m_skip [1:3];
    int m_rr;

    wr_arbiter #(.CNT_WIDTH(CW), .MAX_SKIP(MAX_SKIP), .TIMEOUT(TIMEOUT)) dut (
        .ddr_clk      (ddr_clk),
        .ddr_rst      (ddr_rst),
        .ddr_wreq_cnt1(c1),
        .ddr_wreq_cnt2(c2),
        .ddr_wreq_cnt3(c3),
        .ddr_wrdy     (ddr_wrdy),
        .ddr_wdone    (ddr_wdone),
        .ddr_wreq     (ddr_wreq),
        .wr_opera_en_1(en1),
        .wr_opera_en_2(en2),
        .wr_opera_en_3(en3),
        .grant_id     (grant_id),
        .wr_done      (wr_done),
        .wr_timeout   (wr_timeout),
        .busy         (busy)
    );

    assign en_vec = {en3, en2, en1};

    always #5 ddr_clk = ~ddr_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int en_of(input int g);
        return (g == 0) ? 0 : (1 << (g - 1));
    endfunction

    task automatic check_grant(input string tag, input int g);
        chk(tag, 32'(grant_id), g);
        chk({tag, "_en"}, 32'(en_vec), en_of(g));
    endtask

    task automatic model_reset;
        for (int ch = 1; ch <= 3; ch++) begin
            m_cnt[ch]  = 0;
            m_skip[ch] = 0;
        end
        m_rr = 1;
    endtask

    task automatic set_counts(input int a, input int b, input int cc);
        c1 = CW'(a); c2 = CW'(b); c3 = CW'(cc);
        m_cnt[1] = a; m_cnt[2] = b; m_cnt[3] = cc;
        for (int ch = 1; ch <= 3; ch++)
            if (m_cnt[ch] == 0) m_skip[ch] = 0;
    endtask

    // Starved channel first (lowest number), else largest count, ties from m_rr onwards.
    function automatic int model_winner();
        int mx = 0;
        for (int ch = 1; ch <= 3; ch++)
            if (m_cnt[ch] != 0 && m_skip[ch] >= MAX_SKIP) return ch;
        for (int ch = 1; ch <= 3; ch++)
            if (m_cnt[ch] > mx) mx = m_cnt[ch];
        if (mx == 0) return 0;
        for (int k = 0; k < 3; k++) begin
            int ch = (m_rr - 1 + k) % 3 + 1;
            if (m_cnt[ch] == mx) return ch;
        end
        return 0;
    endfunction

    task automatic model_arbitrate(input int w);
        for (int ch = 1; ch <= 3; ch++) begin
            if (m_cnt[ch] == 0 || ch == w) m_skip[ch] = 0;
            else if (m_skip[ch] < MAX_SKIP) m_skip[ch]++;
        end
    endtask

    task automatic do_reset;
        ddr_rst = 1'b1;
        ddr_wrdy = 1'b0;
        ddr_wdone = 1'b0;
        set_counts(0, 0, 0);
        tick;
        tick;
        ddr_rst = 1'b0;
        model_reset;
    endtask

    task automatic wait_wreq(output int lat);
        lat = 0;
        while (ddr_wreq !== 1'b1 && lat < 8) begin
            tick;
            lat++;
            chk("done_single_pulse", 32'(wr_done), 0);
            chk("timeout_single_pulse", 32'(wr_timeout), 0);
        end
    endtask

    task automatic run_burst(input int a, input int b, input int cc,
                             input int wrdy_dly, input int wdone_dly,
                             input bit both, input bit stray, input bit perturb,
                             output int got);
        int exp_w, lat, hi;
        set_counts(a, b, cc);
        exp_w = model_winner();
        got = 0;
        if (exp_w == 0) begin
            repeat (6) begin
                tick;
                chk("idle_wreq", 32'(ddr_wreq), 0);
                chk("idle_busy", 32'(busy), 0);
                check_grant("idle_grant", 0);
            end
            return;
        end
        wait_wreq(lat);
        chk("turnaround", lat, 2);
        chk("busy_req", 32'(busy), 1);
        got = int'(grant_id);
        check_grant("winner", exp_w);
        model_arbitrate(exp_w);
        hi = 1;
        for (int i = 0; i < wrdy_dly; i++) begin
            if (stray && i == 0) ddr_wdone = 1'b1;
            tick;
            ddr_wdone = 1'b0;
            if (ddr_wreq === 1'b1) hi++;
            check_grant("req_hold", exp_w);
            chk("req_no_done", 32'(wr_done), 0);
        end
        ddr_wrdy = 1'b1;
        if (both) ddr_wdone = 1'b1;
        tick;
        ddr_wrdy = 1'b0;
        ddr_wdone = 1'b0;
        chk("wreq_drop", 32'(ddr_wreq), 0);
        chk("wreq_cycles", hi, wrdy_dly + 1);
        chk("no_done_early", 32'(wr_done), 0);
        check_grant("wait_hold", exp_w);
        if (perturb) begin
            c1 = CW'($urandom_range(1, 60));
            c2 = CW'($urandom_range(1, 60));
            c3 = CW'($urandom_range(1, 60));
        end
        for (int i = 0; i < wdone_dly; i++) begin
            tick;
            check_grant("wait_hold2", exp_w);
            chk("wait_no_done", 32'(wr_done), 0);
            chk("wait_wreq", 32'(ddr_wreq), 0);
        end
        ddr_wdone = 1'b1;
        tick;
        ddr_wdone = 1'b0;
        chk("done_pulse", 32'(wr_done), 1);
        check_grant("grant_drop", 0);
        chk("busy_idle", 32'(busy), 0);
        m_rr = exp_w % 3 + 1;
    endtask

    task automatic run_timeout(input int a, input int b, input int cc,
                               input bit give_wrdy, output int got);
        int exp_w, lat, n;
        set_counts(a, b, cc);
        exp_w = model_winner();
        wait_wreq(lat);
        chk("to_turnaround", lat, 2);
        got = int'(grant_id);
        check_grant("to_winner", exp_w);
        model_arbitrate(exp_w);
        if (give_wrdy) begin
            ddr_wrdy = 1'b1;
            tick;
            ddr_wrdy = 1'b0;
            chk("to_wreq_drop", 32'(ddr_wreq), 0);
        end
        n = 0;
        while (wr_timeout !== 1'b1 && n < 40) begin
            tick;
            n++;
            if (wr_timeout !== 1'b1) begin
                check_grant("to_hold", exp_w);
                chk("to_wreq_hold", 32'(ddr_wreq), give_wrdy ? 0 : 1);
            end
        end
        chk("timeout_latency", n, TIMEOUT);
        chk("to_wreq_clear", 32'(ddr_wreq), 0);
        check_grant("to_grant_clear", 0);
        chk("to_no_done", 32'(wr_done), 0);
        chk("to_busy", 32'(busy), 0);
    endtask

    initial begin
        int got, lat;
        int rr_exp [4];
        rr_exp = '{1, 2, 3, 1};

        do_reset;
        chk("rst_wreq", 32'(ddr_wreq), 0);
        check_grant("rst_grant", 0);
        chk("rst_done", 32'(wr_done), 0);
        chk("rst_timeout", 32'(wr_timeout), 0);
        chk("rst_busy", 32'(busy), 0);

        // Largest count wins; 2-cycle wrdy delay, 10-cycle wdone delay
        run_burst(3, 7, 2, 2, 10, 1'b0, 1'b0, 1'b0, got);
        chk("largest_id", got, 2);

        // All-equal tie rotates from channel 1
        do_reset;
        for (int k = 0; k < 4; k++) begin
            run_burst(5, 5, 5, 1, 3, 1'b0, 1'b0, 1'b0, got);
            chk("rr_order", got, rr_exp[k]);
        end

        // Starvation override after MAX_SKIP losses
        do_reset;
        for (int k = 0; k < 5; k++) begin
            run_burst(1, 9, 0, 0, 2, 1'b0, 1'b0, 1'b0, got);
            chk("skip_order", got, (k < 4) ? 2 : 1);
        end

        // Watchdog in REQ leaves the round-robin pointer alone
        do_reset;
        run_timeout(5, 5, 5, 1'b0, got);
        chk("to_req_id", got, 1);
        run_burst(5, 5, 5, 1, 1, 1'b0, 1'b0, 1'b0, got);
        chk("rr_after_timeout", got, 1);

        // Watchdog in WAIT
        run_timeout(0, 3, 0, 1'b1, got);
        chk("to_wait_id", got, 2);

        // wrdy+wdone together in REQ, stray wdone in REQ, counts change in WAIT
        run_burst(2, 2, 0, 3, 2, 1'b1, 1'b1, 1'b1, got);

        // Reset in WAIT: no done pulse, later wdone ignored
        do_reset;
        set_counts(0, 4, 1);
        wait_wreq(lat);
        chk("r39_lat", lat, 2);
        ddr_wrdy = 1'b1;
        tick;
        ddr_wrdy = 1'b0;
        tick;
        ddr_rst = 1'b1;
        tick;
        ddr_rst = 1'b0;
        set_counts(0, 0, 0);
        model_reset;
        chk("r39_wreq", 32'(ddr_wreq), 0);
        check_grant("r39_grant", 0);
        chk("r39_busy", 32'(busy), 0);
        chk("r39_done", 32'(wr_done), 0);
        chk("r39_timeout", 32'(wr_timeout), 0);
        ddr_wdone = 1'b1;
        tick;
        ddr_wdone = 1'b0;
        chk("r39_stray_done", 32'(wr_done), 0);
        tick;
        chk("r39_stray_done2", 32'(wr_done), 0);
        chk("r39_stray_busy", 32'(busy), 0);

        // All counts zero with random wrdy/wdone noise
        for (int i = 0; i < 100; i++) begin
            ddr_wrdy  = 1'($urandom % 2);
            ddr_wdone = 1'($urandom % 2);
            tick;
            chk("quiet_wreq", 32'(ddr_wreq), 0);
            check_grant("quiet_grant", 0);
            chk("quiet_busy", 32'(busy), 0);
            chk("quiet_done", 32'(wr_done), 0);
        end
        ddr_wrdy  = 1'b0;
        ddr_wdone = 1'b0;

        // Randomized bursts against the model
        for (int k = 0; k < 40; k++) begin
            int a, b, cc;
            a  = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 4));
            b  = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 4));
            cc = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 4));
            run_burst(a, b, cc, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                      1'($urandom % 4 == 0), 1'($urandom % 4 == 0), 1'($urandom % 3 == 0), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
